// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Register file with two asynchronous read ports, two write ports and a
// load scoreboard (one pending bit per register).
//   - Port A (wa_*) is the ALU writeback: full-width writes.
//   - Port B (wb_*) is the load writeback: byte-lane writes under wb_be. Any
//     port-B write, even with wb_be all zero, retires the pending load of
//     that register.
//   - sb_set_* marks a register as awaiting a load. If the same register is
//     marked and retired in one cycle, the new mark wins.
//   - With BYPASS=1 the read ports see this cycle's writes, and a read of a
//     register being retired on port B reports it as not pending.
//   - With ZERO_REG=1 register 0 always reads 0 and is never pending.
//   - leds shows the low LED_W bits of the stored register picked by dbg_sel,
//     one cycle late.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   rd1_addr/rd2_addr    read addresses
//   rd1_data/rd2_data    read data (combinational)
//   rd1_pend/rd2_pend    addressed register awaits a port-B write
//   wa_en/wa_addr/wa_data              port A write
//   wb_en/wb_addr/wb_data/wb_be        port B byte-lane write
//   sb_set_en/sb_set_addr              mark a register pending
//   pend_any             OR of all stored pending bits
//   dbg_sel              debug register select
//   leds                 registered low bits of the selected register
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int LED_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rd1_addr,
    input  logic [ADDR_W-1:0]     rd2_addr,
    output logic [DATA_W-1:0]     rd1_data,
    output logic [DATA_W-1:0]     rd2_data,
    output logic                  rd1_pend,
    output logic                  rd2_pend,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [DATA_W-1:0]     wa_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [DATA_W/8-1:0]   wb_be,
    input  logic                  sb_set_en,
    input  logic [ADDR_W-1:0]     sb_set_addr,
    output logic                  pend_any,
    input  logic [ADDR_W-1:0]     dbg_sel,
    output logic [LED_W-1:0]      leds
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int NLANE = DATA_W / 8;

    logic [DATA_W-1:0] reg_q [NREG];
    logic [DATA_W-1:0] reg_d [NREG];
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;
    logic [LED_W-1:0]  leds_q;

    genvar gi, gj;

    // Next-state of every register and pending bit. The same next value
    // feeds the flops and, with BYPASS=1, the read ports.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign reg_d[gi]  = '0;
                assign pend_d[gi] = 1'b0;
            end else begin : g_live
                logic              wa_hit;
                logic              wb_hit;
                logic              set_hit;
                logic [DATA_W-1:0] nxt;

                assign wa_hit  = wa_en     && (wa_addr     == ADDR_W'(gi));
                assign wb_hit  = wb_en     && (wb_addr     == ADDR_W'(gi));
                assign set_hit = sb_set_en && (sb_set_addr == ADDR_W'(gi));

                // Port B owns the lanes it enables; port A fills the rest.
                for (gj = 0; gj < NLANE; gj++) begin : g_lane
                    assign nxt[8*gj +: 8] =
                        (wb_hit && wb_be[gj]) ? wb_data[8*gj +: 8] :
                        wa_hit                ? wa_data[8*gj +: 8] :
                                                reg_q[gi][8*gj +: 8];
                end

                assign reg_d[gi]  = nxt;
                // A new load mark beats a retiring load to the same register.
                assign pend_d[gi] = set_hit | (pend_q[gi] & ~wb_hit);
            end
        end
    endgenerate

    // Read ports: two identical copies of the same mux.
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [1:0]        rd_pend;

    assign rd_addr[0] = rd1_addr;
    assign rd_addr[1] = rd2_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] sel;
            logic              fwd_clr;

            if (BYPASS != 0) begin : g_byp
                assign sel     = reg_d[rd_addr[gi]];
                assign fwd_clr = wb_en && (wb_addr == rd_addr[gi]);
            end else begin : g_nobyp
                assign sel     = reg_q[rd_addr[gi]];
                assign fwd_clr = 1'b0;
            end

            // The forwarded next value would leak in-flight writes while
            // reset is held, so force reads to zero during reset.
            assign rd_data[gi] = rst ? '0 : sel;
            assign rd_pend[gi] = pend_q[rd_addr[gi]] & ~fwd_clr;
        end
    endgenerate

    assign rd1_data = rd_data[0];
    assign rd2_data = rd_data[1];
    assign rd1_pend = rd_pend[0];
    assign rd2_pend = rd_pend[1];
    assign pend_any = |pend_q;
    assign leds     = leds_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
            pend_q <= '0;
            leds_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= reg_d[i];
            end
            pend_q <= pend_d;
            // Debug view of the stored value, so same-cycle writes are
            // not visible here.
            leds_q <= reg_q[dbg_sel][LED_W-1:0];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Drives three copies of regfile_sb from the same inputs:
//   a_* : defaults (BYPASS=1, ZERO_REG=0)
//   z_* : ZERO_REG=1
//   n_* : BYPASS=0
// Expected values are pushed to exp_q when stimulus is applied. They are
// popped and compared when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [2:0]  rd1_addr, rd2_addr;
    logic        wa_en;
    logic [2:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_be;
    logic        sb_set_en;
    logic [2:0]  sb_set_addr;
    logic [2:0]  dbg_sel;

    logic [31:0] a_rd1_data, a_rd2_data, z_rd1_data, z_rd2_data, n_rd1_data, n_rd2_data;
    logic        a_rd1_pend, a_rd2_pend, z_rd1_pend, z_rd2_pend, n_rd1_pend, n_rd2_pend;
    logic        a_pend_any, z_pend_any, n_pend_any;
    logic [9:0]  a_leds, z_leds, n_leds;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_chk  = 0;
    int          n_pass = 0;

    regfile_sb dut_a (
        .clk(clk), .rst(rst), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(a_rd1_data), .rd2_data(a_rd2_data), .rd1_pend(a_rd1_pend), .rd2_pend(a_rd2_pend),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pend_any(a_pend_any),
        .dbg_sel(dbg_sel), .leds(a_leds)
    );

    regfile_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(z_rd1_data), .rd2_data(z_rd2_data), .rd1_pend(z_rd1_pend), .rd2_pend(z_rd2_pend),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pend_any(z_pend_any),
        .dbg_sel(dbg_sel), .leds(z_leds)
    );

    regfile_sb #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(n_rd1_data), .rd2_data(n_rd2_data), .rd1_pend(n_rd1_pend), .rd2_pend(n_rd2_pend),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pend_any(n_pend_any),
        .dbg_sel(dbg_sel), .leds(n_leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        wa_en     = 1'b0;
        wb_en     = 1'b0;
        wb_be     = 4'h0;
        sb_set_en = 1'b0;
    endtask

    task automatic test_reset();
        // In-flight write during reset must not show through the bypass path.
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 32'hFFFF_FFFF; rd1_addr = 3'd3; rd2_addr = 3'd3;
        sb_set_en = 1'b1; sb_set_addr = 3'd3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL reset_rd1_bypass: got %h expected %h", a_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (n_rd1_data !== e) $display("FAIL reset_rd1_nobypass: got %h expected %h", n_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd1_pend) !== e) $display("FAIL reset_rd1_pend: got %h expected %h", a_rd1_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL reset_pend_any: got %h expected %h", a_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_leds) !== e) $display("FAIL reset_leds: got %h expected %h", a_leds, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd2_data !== e) $display("FAIL reset_rd2_bypass: got %h expected %h", a_rd2_data, e); else n_pass++;
        idle();
        rst = 1'b0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL reset_no_write_landed: got %h expected %h", a_rd1_data, e); else n_pass++;
    endtask

    task automatic test_basic_write();
        @(posedge clk); #1;
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 32'hDEAD_BEEF; rd1_addr = 3'd3; rd2_addr = 3'd3;
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL basic_bypass: got %h expected %h", a_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (n_rd1_data !== e) $display("FAIL basic_nobypass_old: got %h expected %h", n_rd1_data, e); else n_pass++;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL basic_stored_rd1: got %h expected %h", a_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd2_data !== e) $display("FAIL basic_stored_rd2: got %h expected %h", a_rd2_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (n_rd1_data !== e) $display("FAIL basic_nobypass_new: got %h expected %h", n_rd1_data, e); else n_pass++;
    endtask

    task automatic test_collision();
        @(posedge clk); #1;
        wa_en = 1'b1; wa_addr = 3'd5; wa_data = 32'h1111_1111;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 32'hAAAA_AAAA; wb_be = 4'b0101;
        rd1_addr = 3'd5; rd2_addr = 3'd5;
        exp_q.push_back(32'h11AA_11AA);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL collision_bypass: got %h expected %h", a_rd1_data, e); else n_pass++;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'h11AA_11AA); exp_q.push_back(32'h11AA_11AA);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (n_rd2_data !== e) $display("FAIL collision_stored_n: got %h expected %h", n_rd2_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd2_data !== e) $display("FAIL collision_stored_a: got %h expected %h", a_rd2_data, e); else n_pass++;
    endtask

    task automatic test_scoreboard();
        rd2_addr = 3'd2;
        @(posedge clk); #1;
        sb_set_en = 1'b1; sb_set_addr = 3'd2;
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL sb_set_not_yet: got %h expected %h", a_pend_any, e); else n_pass++;
        // Port-A write must leave the mark alone.
        @(posedge clk); #1;
        idle();
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 32'h0000_1234;
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd2_pend) !== e) $display("FAIL sb_set_rd2_pend: got %h expected %h", a_rd2_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL sb_set_pend_any: got %h expected %h", a_pend_any, e); else n_pass++;
        // Port-B write with no byte enables still retires the load.
        @(posedge clk); #1;
        idle();
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'hFFFF_FFFF; wb_be = 4'b0000;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0000_1234);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd2_pend) !== e) $display("FAIL sb_clr_bypass_pend: got %h expected %h", a_rd2_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(n_rd2_pend) !== e) $display("FAIL sb_clr_nobypass_pend: got %h expected %h", n_rd2_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL sb_clr_pend_any_stored: got %h expected %h", a_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd2_data !== e) $display("FAIL sb_clr_be0_data: got %h expected %h", a_rd2_data, e); else n_pass++;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL sb_clr_pend_any: got %h expected %h", a_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd2_pend) !== e) $display("FAIL sb_clr_rd2_pend: got %h expected %h", a_rd2_pend, e); else n_pass++;
        // Mark and retire together: the mark survives.
        @(posedge clk); #1;
        sb_set_en = 1'b1; sb_set_addr = 3'd2;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'hCAFE_F00D; wb_be = 4'b1111;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd2_pend) !== e) $display("FAIL sb_set_wins_pend: got %h expected %h", a_rd2_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL sb_set_wins_any: got %h expected %h", a_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd2_data !== e) $display("FAIL sb_set_wins_data: got %h expected %h", a_rd2_data, e); else n_pass++;
        @(posedge clk); #1;
        wb_en = 1'b1; wb_addr = 3'd2; wb_be = 4'b0000;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_zero_reg();
        @(posedge clk); #1;
        wa_en = 1'b1; wa_addr = 3'd0; wa_data = 32'h5;
        sb_set_en = 1'b1; sb_set_addr = 3'd0; rd1_addr = 3'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h5);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (z_rd1_data !== e) $display("FAIL zero_bypass_z: got %h expected %h", z_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL zero_bypass_a: got %h expected %h", a_rd1_data, e); else n_pass++;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h5); exp_q.push_back(32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (z_rd1_data !== e) $display("FAIL zero_stored_z: got %h expected %h", z_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(z_rd1_pend) !== e) $display("FAIL zero_pend_z: got %h expected %h", z_rd1_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(z_pend_any) !== e) $display("FAIL zero_pend_any_z: got %h expected %h", z_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL zero_stored_a: got %h expected %h", a_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd1_pend) !== e) $display("FAIL zero_pend_a: got %h expected %h", a_rd1_pend, e); else n_pass++;
        @(posedge clk); #1;
        wb_en = 1'b1; wb_addr = 3'd0; wb_be = 4'b0000;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_leds();
        rd1_addr = 3'd1; dbg_sel = 3'd1;
        @(posedge clk); #1;
        wa_en = 1'b1; wa_addr = 3'd1; wa_data = 32'h0000_03FF;
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (n_rd1_data !== e) $display("FAIL leds_nobypass_old: got %h expected %h", n_rd1_data, e); else n_pass++;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'h3FF); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (n_rd1_data !== e) $display("FAIL leds_nobypass_new: got %h expected %h", n_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(n_leds) !== e) $display("FAIL leds_not_yet: got %h expected %h", n_leds, e); else n_pass++;
        @(posedge clk); #1;
        exp_q.push_back(32'h3FF);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(n_leds) !== e) $display("FAIL leds_r1: got %h expected %h", n_leds, e); else n_pass++;
        @(posedge clk); #1;
        dbg_sel = 3'd3;
        @(posedge clk); #1;
        exp_q.push_back(32'h2EF);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_leds) !== e) $display("FAIL leds_r3: got %h expected %h", a_leds, e); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] m6;
        logic [31:0] nxt;
        m6 = 32'h0;
        rd1_addr = 3'd6; rd2_addr = 3'd6;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wa_en = 1'($urandom_range(0, 1)); wa_addr = 3'd6; wa_data = $urandom;
            wb_en = 1'($urandom_range(0, 1)); wb_addr = 3'd6; wb_data = $urandom;
            wb_be = 4'($urandom_range(0, 15));
            nxt = m6;
            for (int l = 0; l < 4; l++) begin
                if (wb_en && wb_be[l]) nxt[8*l +: 8] = wb_data[8*l +: 8];
                else if (wa_en)        nxt[8*l +: 8] = wa_data[8*l +: 8];
            end
            exp_q.push_back(m6); exp_q.push_back(nxt);
            m6 = nxt;
            @(negedge clk);
            e = exp_q.pop_front(); n_chk++;
            if (n_rd2_data !== e) $display("FAIL b2b_stored[%0d]: got %h expected %h", i, n_rd2_data, e); else n_pass++;
            e = exp_q.pop_front(); n_chk++;
            if (a_rd1_data !== e) $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, a_rd1_data, e); else n_pass++;
        end
        @(posedge clk); #1;
        idle();
        exp_q.push_back(m6);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (n_rd2_data !== e) $display("FAIL b2b_final: got %h expected %h", n_rd2_data, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        sb_set_en = 1'b1; sb_set_addr = 3'd6;
        @(posedge clk); #1;
        idle();
        wa_en = 1'b1; wa_addr = 3'd7; wa_data = 32'h0000_0077;
        sb_set_en = 1'b1; sb_set_addr = 3'd4;
        rd1_addr = 3'd7; rd2_addr = 3'd6;
        exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL rstmid_pre_pend_any: got %h expected %h", a_pend_any, e); else n_pass++;
        rst = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL rstmid_rd1_data: got %h expected %h", a_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_rd2_pend) !== e) $display("FAIL rstmid_rd2_pend: got %h expected %h", a_rd2_pend, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL rstmid_pend_any: got %h expected %h", a_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_leds) !== e) $display("FAIL rstmid_leds: got %h expected %h", a_leds, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (n_rd2_data !== e) $display("FAIL rstmid_rd2_data: got %h expected %h", n_rd2_data, e); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (a_rd1_data !== e) $display("FAIL rstmid_no_write: got %h expected %h", a_rd1_data, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_pend_any) !== e) $display("FAIL rstmid_no_set: got %h expected %h", a_pend_any, e); else n_pass++;
        e = exp_q.pop_front(); n_chk++;
        if (32'(a_leds) !== e) $display("FAIL rstmid_leds_after: got %h expected %h", a_leds, e); else n_pass++;
        // Normal operation resumes.
        @(posedge clk); #1;
        wa_en = 1'b1; wa_addr = 3'd7; wa_data = 32'h0000_0077;
        @(posedge clk); #1;
        idle();
        exp_q.push_back(32'h77);
        @(negedge clk);
        e = exp_q.pop_front(); n_chk++;
        if (n_rd1_data !== e) $display("FAIL rstmid_resume: got %h expected %h", n_rd1_data, e); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        rd1_addr = '0; rd2_addr = '0;
        wa_addr = '0; wa_data = '0; wb_addr = '0; wb_data = '0;
        sb_set_addr = '0; dbg_sel = '0;
        idle();
        test_reset();
        test_basic_write();
        test_collision();
        test_scoreboard();
        test_zero_reg();
        test_leds();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; depth NREG = 2^ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 means register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; 1 means same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter LED_W, default 10, debug LED width; legal range is LED_W <= DATA_W.
REQ-006 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd1_addr, rd2_addr  in  ADDR_W  read port addresses.
- rd1_data, rd2_data  out  DATA_W  read data, combinational.
- rd1_pend, rd2_pend  out  1  the addressed register awaits a port-B write.
- wa_en  in  1  port A (ALU) write enable.
- wa_addr  in  ADDR_W  port A write address.
- wa_data  in  DATA_W  port A write data.
- wb_en  in  1  port B (load) write enable.
- wb_addr  in  ADDR_W  port B write address.
- wb_data  in  DATA_W  port B write data.
- wb_be  in  DATA_W/8  port B byte enables.
- sb_set_en  in  1  mark a register pending (load issued).
- sb_set_addr  in  ADDR_W  register to mark pending.
- pend_any  out  1  OR of all pending bits.
- dbg_sel  in  ADDR_W  debug register select.
- leds  out  LED_W  registered low bits of the selected register.

Function
REQ-007 SHALL hold NREG registers of DATA_W bits and one pending bit per register.
REQ-008 SHALL compute the next value of register r lane by lane (lane i = byte i):
- wb_data lane if wb_en, wb_addr==r and wb_be[i];
- else wa_data lane if wa_en and wa_addr==r;
- else the current lane value.
REQ-009 SHALL, when port A and port B target the same address in one cycle, take each lane from port B where wb_be is set and from port A elsewhere.
REQ-010 SHALL update registers on the rising clk edge only.
REQ-011 SHALL, with BYPASS=1, drive rdN_data with the REQ-008 next value of the addressed register.
REQ-012 SHALL, with BYPASS=0, drive rdN_data with the stored register value.
REQ-013 SHALL, with ZERO_REG=1, ignore writes to register 0, never set its pending bit, read it as 0 and report its pend as 0.
REQ-014 SHALL, with sb_set_en, set pending[sb_set_addr] at the clock edge.
REQ-015 SHALL clear pending[wb_addr] at the edge of a port-B write (wb_en=1), for any wb_be value including all-zero.
REQ-016 SHALL, on a simultaneous set and clear of the same address, leave the pending bit set (set wins).
REQ-017 SHALL NOT change pending bits on port-A writes.
REQ-018 SHALL drive rdN_pend = pending[rdN_addr].
- With BYPASS=1, SHALL force rdN_pend to 0 when wb_en=1 and wb_addr==rdN_addr in the same cycle.
REQ-019 SHALL drive pend_any as the OR of all stored pending bits (not bypassed).
REQ-020 SHALL register leds at each edge from bits [LED_W-1:0] of the stored register selected by dbg_sel; latency is 1 cycle and the value does not include same-cycle writes.
REQ-021 SHALL give both read ports identical, independent behaviour; identical read addresses return identical data.

Reset
REQ-022 SHALL, while rst=1 asynchronously, clear all registers, all pending bits and leds to 0.
REQ-023 SHALL, when reset is asserted mid-operation, discard any write or set of that cycle.
REQ-024 SHALL give these values in reset: pend_any=0, rdN_pend=0, rdN_data=0 under BYPASS=0 and under BYPASS=1.
REQ-025 SHALL resume normal operation at the first rising edge after rst deasserts.

Verification
REQ-026 Basic write/read, defaults: wa write r3=0xDEADBEEF -> rd1_addr=3 reads 0xDEADBEEF in the same cycle (bypass) and after the edge.
REQ-027 Write collision: same cycle wa r5=0x11111111, wb r5=0xAAAAAAAA with wb_be=4'b0101 -> r5=0x11AA11AA.
REQ-028 Scoreboard:
- sb_set r2 -> rd2_pend=1 and pend_any=1 next cycle;
- wa write r2 -> pend stays 1;
- wb write r2 -> rd2_pend=0 in the same cycle (bypass) and pend_any=0 after the edge;
- simultaneous set and wb to r2 -> pend remains 1.
REQ-029 Zero register: ZERO_REG=1, write r0=0x5 and sb_set r0 -> rd r0=0, pend=0; with ZERO_REG=0, r0=0x5.
REQ-030 Bypass off plus LEDs: BYPASS=0, write r1=0x3FF -> rd1 reads old value until the edge; dbg_sel=1 -> leds=0x3FF one cycle after the write is stored.
REQ-031 Reset mid-operation: assert rst between edges with writes and sets pending -> all reads, pend bits, pend_any and leds go 0 immediately; no write lands.
